// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SW-bit slice is rippled per stage, carry registered between stages.
// Optional signed-overflow output is built only when RCA_PIPE_OVF_EN is defined; otherwise ovf is tied to 0.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Bit-serial ripple over one slice; returns {carry_out, slice_sum}.
    function automatic logic [SW:0] ripple(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                           input logic c);
        logic [SW:0] r;
        logic        cy;
        cy = c;
        for (int i = 0; i < SW; i++) begin
            r[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        r[SW] = cy;
        return r;
    endfunction

    // Working word: finished slices enter at the top while the unsummed A bits drain out of the bottom,
    // so after STAGES rotations the word is exactly the result in natural bit order.
    function automatic logic [WIDTH-1:0] rotate(input logic [SW-1:0] s, input logic [WIDTH-1:0] w);
        logic [WIDTH+SW-1:0] t;
        t = {s, w} >> SW;
        return t[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] ws_p  [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];
    logic [SW:0]      add_p [STAGES];
    logic             en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            add_p[k] = ripple(ws_p[k][SW-1:0], b_p[k][SW-1:0], c_p[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ws_p[k]  <= '0;
                b_p[k]   <= '0;
                c_p[k]   <= 1'b0;
                vld_p[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (en) begin
            // Stage 0 boundary: capture operands with B and carry already inverted for SUB
            vld_p[0] <= in_valid;
            ws_p[0]  <= a;
            b_p[0]   <= mode ? ~b : b;
            c_p[0]   <= cin ^ mode;
            // Stage k -> k+1 boundary: slice k done, its carry feeds slice k+1
            for (int k = 0; k < STAGES - 1; k++) begin
                vld_p[k+1] <= vld_p[k];
                ws_p[k+1]  <= rotate(add_p[k][SW-1:0], ws_p[k]);
                b_p[k+1]   <= b_p[k] >> SW;
                c_p[k+1]   <= add_p[k][SW];
            end
            // Output boundary: bubbles drop out_valid but leave the last result on sum/cout
            out_valid <= vld_p[LAST];
            if (vld_p[LAST]) begin
                sum  <= rotate(add_p[LAST][SW-1:0], ws_p[LAST]);
                cout <= add_p[LAST][SW];
            end
        end
    end

`ifdef RCA_PIPE_OVF_EN
    // Carry into the MSB of the top slice, taken on the effective operands.
    function automatic logic msb_carry(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                       input logic c);
        logic cy;
        cy = c;
        for (int i = 0; i < SW - 1; i++) begin
            cy = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        return cy;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (en && vld_p[LAST]) begin
            ovf <= msb_carry(ws_p[LAST][SW-1:0], b_p[LAST][SW-1:0], c_p[LAST]) ^ add_p[LAST][SW];
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe (WIDTH=16, STAGES=4): driver pushes model results, monitor pops on each handshake.
module tb_rca_pipe;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    rca_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    res_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          gaps = 0;
    int          last_cyc = 0;
    int          nout = 0;
    int          n0 = 0;
    int          w = 0;
    bit          stream = 0;
    bit          have_last = 0;
    bit          done = 0;
    logic [15:0] last_sum = '0;
    logic [15:0] rx, ry;
    logic        rc, rm;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic md);
        int   r;
        int   sr;
        res_t e;
        if (!md) begin
            r   = int'(x) + int'(y) + int'(ci);
            sr  = int'($signed(x)) + int'($signed(y)) + int'(ci);
            e.c = (r > 65535);
        end else begin
            r   = int'(x) - int'(y) - int'(ci);
            sr  = int'($signed(x)) - int'($signed(y)) - int'(ci);
            e.c = (r >= 0);
        end
        e.s = r[15:0];
`ifdef RCA_PIPE_OVF_EN
        e.o = (sr > 32767) || (sr < -32768);
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got result %0h expected none", sum);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.o));
                last_sum = e.s;
                nout++;
            end
            if (stream) begin
                if (have_last && cyc != last_cyc + 1) gaps++;
                have_last = 1;
                last_cyc  = cyc;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic md, output int waits);
        int n;
        bit ok;
        a = x; b = y; cin = ci; mode = md; in_valid = 1'b1;
        waits = 0; ok = 0; n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (!ok) waits++;
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at %0b expected 1", in_ready);
        end else begin
            q.push_back(model(x, y, ci, md));
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic rand_op();
        rx = 16'($urandom);
        ry = 16'($urandom);
        rc = 1'($urandom);
        rm = 1'($urandom);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry out of the top slice and latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1 chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_rise", 32'(out_valid), 32'd1);
        chk("wrap_sum", 32'(sum), 32'h0000);
        chk("wrap_cout", 32'(cout), 32'd1);
        drain();

        send(16'h0005, 16'h0007, 1'b0, 1'b1, w);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, w);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, w);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, w);
        drain();

        // Back-to-back stream
        gaps = 0; have_last = 0; stream = 1; n0 = nout;
        for (int i = 0; i < 8; i++) begin
            rand_op();
            send(rx, ry, rc, rm, w);
            chk("b2b_wait", 32'(w), 32'd0);
        end
        drain();
        stream = 0;
        chk("b2b_count", 32'(nout - n0), 32'd8);
        chk("b2b_gaps", 32'(gaps), 32'd0);

        // Bubble at output: out_valid drops, sum keeps last result
        repeat (2) @(posedge clk);
        #1 chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_sum", 32'(sum), 32'(last_sum));

        // Stall with a full pipe
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_op();
            send(rx, ry, rc, rm, w);
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(q[0].s));
            chk("stall_cout", 32'(cout), 32'(q[0].c));
            @(posedge clk); #1;
        end
        gaps = 0; have_last = 0; stream = 1; n0 = nout;
        drain();
        stream = 0;
        chk("stall_count", 32'(nout - n0), 32'd5);
        chk("stall_gaps", 32'(gaps), 32'd0);

        // Reset with operations in flight
        for (int i = 0; i < 4; i++) begin
            rand_op();
            send(rx, ry, rc, rm, w);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1 chk("rst_hold_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1 chk("post_rst_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_sum", 32'(sum), 32'h2345);
        drain();

        // Random traffic with random backpressure
        n0 = nout; done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    rand_op();
                    send(rx, ry, rc, rm, w);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        chk("rand_count", 32'(nout - n0), 32'd150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
